// File: rtl/cory_arb4_pkg.sv
// Shared types for the cory arbiter family: requester count, index width, FSM states.
// No logic; imported by cory_rr_pick4 and cory_arb4.
// Backpressure: not applicable.
package cory_arb4_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cory_rr_pick4.sv
// Rotating-priority pick: first set request at or above ptr, modulo 4.
// Latency: purely combinational.
// Backpressure: none, the caller qualifies the pick.
module cory_rr_pick4
    import cory_arb4_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] k;

    // Walk from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        k     = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = ptr + IDX_W'(i);
            if (req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/cory_arb4.sv
// Round-robin 4:1 valid/ready arbiter with optional burst lock and source id tag.
// Latency: 1 cycle through the output register, 1 beat/cycle sustained.
// Backpressure: requester ready = output register free or draining this cycle.
module cory_arb4
    import cory_arb4_pkg::*;
#(
    parameter int N    = 8,
    parameter bit LOCK = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_a0_v,
    input  logic [N-1:0]     i_a0_d,
    input  logic             i_a0_l,
    output logic             o_a0_r,
    input  logic             i_a1_v,
    input  logic [N-1:0]     i_a1_d,
    input  logic             i_a1_l,
    output logic             o_a1_r,
    input  logic             i_a2_v,
    input  logic [N-1:0]     i_a2_d,
    input  logic             i_a2_l,
    output logic             o_a2_r,
    input  logic             i_a3_v,
    input  logic [N-1:0]     i_a3_d,
    input  logic             i_a3_l,
    output logic             o_a3_r,
    output logic             o_z_v,
    output logic [N-1:0]     o_z_d,
    output logic             o_z_l,
    output logic [IDX_W-1:0] o_z_id,
    input  logic             i_z_r,
    output logic             o_busy
);

    logic [NREQ-1:0]  req_v;
    logic [NREQ-1:0]  req_l;
    logic [N-1:0]     req_d [NREQ];

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             locked;
    logic [IDX_W-1:0] sel;
    logic             sel_valid;
    logic             load;
    logic [NREQ-1:0]  rdy_vec;
    logic             accept;
    logic             last_eff;

    assign req_v    = {i_a3_v, i_a2_v, i_a1_v, i_a0_v};
    assign req_l    = {i_a3_l, i_a2_l, i_a1_l, i_a0_l};
    assign req_d[0] = i_a0_d;
    assign req_d[1] = i_a1_d;
    assign req_d[2] = i_a2_d;
    assign req_d[3] = i_a3_d;

    cory_rr_pick4 u_pick (
        .req   (req_v),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // While locked the owner keeps the slot even across its own valid gaps.
    assign locked    = (state == ARB_LOCK);
    assign sel       = locked ? gnt : pick_idx;
    assign sel_valid = locked | pick_found;
    assign load      = !o_z_v | i_z_r;
    assign rdy_vec   = (load && sel_valid) ? (NREQ'(1) << sel) : '0;
    assign accept    = |(rdy_vec & req_v);
    assign last_eff  = req_l[sel] | !LOCK;

    assign o_a0_r = rdy_vec[0];
    assign o_a1_r = rdy_vec[1];
    assign o_a2_r = rdy_vec[2];
    assign o_a3_r = rdy_vec[3];
    assign o_busy = locked;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_z_v  <= 1'b0;
            o_z_d  <= '0;
            o_z_l  <= 1'b0;
            o_z_id <= '0;
            state  <= ARB_IDLE;
            ptr    <= '0;
            gnt    <= '0;
        end else begin
            if (load) begin
                o_z_v <= accept;
                if (accept) begin
                    o_z_d  <= req_d[sel];
                    o_z_l  <= req_l[sel];
                    o_z_id <= sel;
                end
            end
            if (accept) begin
                case (state)
                    ARB_IDLE: begin
                        if (!last_eff) begin
                            gnt   <= sel;
                            state <= ARB_LOCK;
                        end else begin
                            ptr <= sel + IDX_W'(1);
                        end
                    end
                    ARB_LOCK: begin
                        if (last_eff) begin
                            ptr   <= gnt + IDX_W'(1);
                            state <= ARB_IDLE;
                        end
                    end
                    default: state <= ARB_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/cory_arb4.md
Name: cory_arb4

Overview:
- Round-robin arbiter that shares one valid/ready output stream among 4 requester streams.
- Optional burst (packet) lock: once a requester is granted, it keeps the grant until it sends its last beat.
- Sits in front of a cory_pack*/downstream consumer wherever several producers contend for one channel.
- The output is registered: one pipeline stage, full throughput, and the source index is tagged on each beat.

Parameters:
- N, 8, data width of each input and of the output.
- LOCK, 1: 1 means the grant is held until an accepted beat with last=1. 0 means every beat is treated as last, so arbitration happens per beat.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- i_a0_v / i_a1_v / i_a2_v / i_a3_v  input  1  requester k valid
- i_a0_d / i_a1_d / i_a2_d / i_a3_d  input  N  requester k data
- i_a0_l / i_a1_l / i_a2_l / i_a3_l  input  1  requester k last-beat-of-burst
- o_a0_r / o_a1_r / o_a2_r / o_a3_r  output  1  requester k ready
- o_z_v  output  1  output valid (registered)
- o_z_d  output  N  output data (registered)
- o_z_l  output  1  output last (registered)
- o_z_id  output  2  index of the source requester (registered)
- i_z_r  input  1  output ready
- o_busy  output  1  high while in LOCKED state

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset_n is synchronous and active-low. It is sampled on the rising edge of clk only.
- Reset values:
  - o_z_v=0, o_z_d=0, o_z_l=0, o_z_id=0, o_busy=0.
  - State=IDLE, pointer ptr=0, grant register gnt=0.
- Output register:
  - load = !o_z_v | i_z_r.
  - o_aK_r = load & sel_valid & (sel==K). It is combinational from i_z_r and o_z_v; at most one o_aK_r is high in any cycle.
  - An input beat is accepted when i_aK_v & o_aK_r. On acceptance the register captures d, l and K, and o_z_v<=1 on the next edge.
  - If load=1 and no beat is accepted, o_z_v<=0.
  - Latency is 1 cycle. Back-to-back beats are supported at 1 beat/cycle.
- Output stability: while o_z_v=1 & i_z_r=0, o_z_d, o_z_l and o_z_id hold stable.
- IDLE state:
  - sel is the first K with i_aK_v=1, searching from ptr upward modulo 4 (rotating priority).
  - If there is no valid requester, there is no selection.
- Accepting a beat in IDLE:
  - With LOCK=1 and l=0: gnt<=sel and the state goes to LOCKED.
  - Otherwise (l=1, or LOCK=0): ptr<=sel+1 (mod 4) and the state stays IDLE.
- LOCKED state:
  - sel=gnt unconditionally. Other requesters see ready=0 even if the granted requester deasserts valid (bubbles are allowed and the grant is held).
  - Accepting a beat with l=1 sets ptr<=gnt+1 and returns to IDLE.
  - Accepting a beat with l=0 stays in LOCKED.
- o_busy is the registered indication of state==LOCKED.
- Fairness: with all 4 requesters continuously valid and single-beat bursts, the grant order is 0,1,2,3,0,...
- Wrap-around: ptr=3 with a grant to 3 sets ptr to 0.
- Input valid rule: a requester must not drop i_aK_v before acceptance. The block does not check this; the SIM monitor may flag it.
- Reset mid-burst:
  - The state returns to IDLE and ptr to 0, and o_z_v clears on that edge.
  - The in-flight register contents are discarded. Upstream senders are responsible for the lost burst.
- Simultaneous events: when the output drains (i_z_r=1) and a new beat is accepted in the same cycle, the register reloads with no bubble.
- Simulation monitor: under `ifdef SIM / CORY_MON, a cory_monitor is instantiated on the z port.

Decomposition:
- Shared include cory_defs.vh:
  - state encodings CORY_ARB_IDLE=1'b0 and CORY_ARB_LOCK=1'b1;
  - the rotating-pick index width macro.
- Sub-module cory_rr_pick4, purely combinational:
  - inputs: 4-bit request vector and 2-bit ptr;
  - outputs: found and 2-bit index.
  - It is reusable by future arbiters (cory_arb8 is built from two of these plus a top-level picker, mirroring the pack tree style).

Test Plan:
- Single requester, LOCK=1, i_z_r=1:
  - Stimulus: a2 sends d=0x11,l=0, then 0x22,l=0, then 0x33,l=1.
  - Response: z shows 0x11,0x22,0x33 in 3 consecutive cycles, each 1 cycle after acceptance, with id=2.
  - o_busy=1 from after the first beat until the edge after 0x33 is accepted.
- All 4 requesters valid, all l=1, i_z_r=1:
  - Response: id sequence 0,1,2,3,0,1 and o_z_v stays continuously high.
- Lock holds against contention:
  - Stimulus: a1 starts a 3-beat burst; a0 and a3 are valid throughout; a1 inserts a 1-cycle valid gap mid-burst.
  - Response: o_a0_r=o_a3_r=0 until the a1 last beat is accepted, then a3 is granted next (ptr=2 → first valid ≥2 is 3).
- Backpressure:
  - Stimulus: i_z_r=0 for 5 cycles while the register is full (d=0xA5).
  - Response: o_z_d stays 0xA5, all o_aK_r=0, and no beat is lost when i_z_r returns to 1.
- Reset mid-burst:
  - Stimulus: assert reset_n=0 for 1 cycle during a0's burst.
  - Response: o_z_v=0, o_busy=0 on the next edge; the next arbitration starts from ptr=0.
- LOCK=0 instance:
  - Stimulus: a0 and a1 both stream with l=0.
  - Response: beats interleave with ids 0,1,0,1 and o_busy is never asserted.
